traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised two-axis intersection controller: successor to the fixed 68-tick traffic sequencer. It derives a phase tick from `clk` through a prescaler and runs a horizontal/vertical car cycle with per-phase durations set by parameters. It adds latched pedestrian requests, a registered walker-flash blink that replaces clock-gated blinking, and a night (flashing-yellow) mode. It sits between the board-level start/mode inputs and the lamp drivers.

## Interface
- `TICK_DIV`, 50_000_000: `clk` cycles per phase tick (≥1)
- `CNT_W`, 8: width of the phase tick counter; every `T_*` must be < 2^CNT_W
- `T_GREEN`, 20: ticks of straight green per axis
- `T_YELLOW`, 2: ticks of each yellow phase
- `T_LEFT`, 10: ticks of left-turn phase per axis
- `T_FLASH`, 6: final ticks of a walker-green window that flash (≤ `T_GREEN`)
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `i_start` in 1: run enable; low forces IDLE
- `i_night` in 1: night-mode request, level
- `i_h_walk_req` in 1: horizontal pedestrian button, single-cycle pulse or level
- `i_v_walk_req` in 1: vertical pedestrian button
- `o_h_car_traffic` out 4: {RED,YELLOW,LEFT,GREEN} one-hot, 0 = off
- `o_v_car_traffic` out 4: same encoding
- `o_h_walker_traffic` out 2: {RED,GREEN}, 0 = off
- `o_v_walker_traffic` out 2: same
- `o_state` out 4: current state code, for debug/verification
- `o_cycle_done` out 1: one-cycle pulse when V_YEL2 completes

## Operation
- States: IDLE, H_GREEN, H_YEL1, H_LEFT, H_YEL2, V_GREEN, V_YEL1, V_LEFT, V_YEL2, NIGHT.
- Normal ring: H_GREEN(T_GREEN) → H_YEL1(T_YELLOW) → H_LEFT(T_LEFT) → H_YEL2(T_YELLOW) → V_GREEN … → V_YEL2 → H_GREEN.
- Car lamps: the active axis shows the state's colour. The other axis shows RED.
- Walker lamps: the vertical walker is associated with H_GREEN and the horizontal walker with V_GREEN. All other states show walker RED for that axis.
- Walker requests are latched in `h_req`/`v_req` on any clock where the input is high.
- On entry to H_GREEN, `v_req` is consumed and cleared, and the vertical walker is granted for that whole phase. V_GREEN handles `h_req` symmetrically.
- A request arriving on the same clock as entry to the green phase is consumed.
- A request arriving later is held for the next cycle.
- If no request is pending at green entry, that walker stays RED.
- Granted walker: GREEN for the first T_GREEN−T_FLASH ticks. For the final T_FLASH ticks it alternates GREEN / off, starting with GREEN. Blink is a registered toggle flipped on every tick. `clk` is never used as data.
- Night mode:
  - `i_night` is sampled at V_YEL2 completion. If high, the next state is NIGHT instead of H_GREEN.
  - In NIGHT, both car outputs show YELLOW / off, toggling each tick. Both walker outputs are off. Requests are still latched.
  - When `i_night` is low on a tick in NIGHT, the next state is H_GREEN.
- `i_start` low: synchronous return to IDLE on the next clock from any state. In IDLE all outputs are 0 and prescaler, phase counter, blink and request latches are cleared.
- IDLE with `i_start` high: next clock enters H_GREEN, with the phase counter loaded with T_GREEN−1 and the prescaler at 0.

## Timing
- Reset: state IDLE, all outputs 0, `o_state`=0, counters/latches 0.
- A tick is asserted when prescaler = TICK_DIV−1. The prescaler then wraps to 0. TICK_DIV=1 means tick every clock.
- Phase counter loads T_x−1 on state entry and decrements on each tick. On a tick with counter 0 the state advances.
- Each phase lasts exactly T_x·TICK_DIV clocks.
- All lamp outputs are registered from next-state logic. Lamps change on the same clock edge as the state register, with no extra latency.
- `o_cycle_done` is high for the single clock following the V_YEL2 → H_GREEN/NIGHT transition edge.
- Simultaneous events:
  - `i_start` low beats every other input.
  - Asynchronous `reset` beats `i_start`.
  - Reset mid-phase aborts immediately. After release with `i_start` high, the sequence resumes at H_GREEN.

## Structure
- Package `traffic_pkg`: lamp encodings (C_RED, C_YELLOW, C_LEFT, C_GREEN, C_NONE, W_RED, W_GREEN, W_NONE) and the state enum with fixed codes IDLE=0 … NIGHT=9.
- Sub-module `tick_gen` (params TICK_DIV; ports clk, reset, clr, o_tick): the prescaler.
- FSM, counters, request latches and output registers live in the top.

## Test plan
Bench parameters: TICK_DIV=2, T_GREEN=4, T_YELLOW=1, T_LEFT=2, T_FLASH=2.
- Reset, then `i_start`=1 → H_GREEN for 8 clocks with h_car=0001, v_car=1000. Then H_YEL1 for 2 clocks (0100). Full ring is 32 clocks, and `o_cycle_done` pulses once per ring.
- `i_v_walk_req` pulse during H_LEFT → v_walker RED until the next H_GREEN. Then GREEN for 4 clocks, then alternating 01/00 every 2 clocks for 4 clocks. The latch is cleared.
- `i_h_walk_req` on the same clock as V_GREEN entry → h_walker granted in that V_GREEN, not the next one.
- `i_night`=1 mid-ring → the ring completes, then NIGHT with both cars 0100/0000 toggling every 2 clocks and walkers 00. Dropping `i_night` → H_GREEN at the next tick.
- `i_start` low during V_LEFT → IDLE next clock with all outputs 0. Reassert → H_GREEN with a fresh 8-clock phase.
- Async `reset` pulse mid-H_GREEN (not aligned to `clk`) → outputs 0 immediately. After release the sequence restarts at H_GREEN.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp encodings, state codes and ring order for traffic_ctrl_param
package traffic_pkg;

    localparam logic [3:0] C_RED    = 4'b1000;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_LEFT   = 4'b0010;
    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_NONE   = 4'b0000;
    localparam logic [1:0] W_RED    = 2'b10;
    localparam logic [1:0] W_GREEN  = 2'b01;
    localparam logic [1:0] W_NONE   = 2'b00;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        H_GREEN = 4'd1,
        H_YEL1  = 4'd2,
        H_LEFT  = 4'd3,
        H_YEL2  = 4'd4,
        V_GREEN = 4'd5,
        V_YEL1  = 4'd6,
        V_LEFT  = 4'd7,
        V_YEL2  = 4'd8,
        NIGHT   = 4'd9
    } state_t;

    // Successor in the normal day ring; night diversion is decided by the caller.
    function automatic state_t ring_next(input state_t s);
        case (s)
            H_GREEN: return H_YEL1;
            H_YEL1:  return H_LEFT;
            H_LEFT:  return H_YEL2;
            H_YEL2:  return V_GREEN;
            V_GREEN: return V_YEL1;
            V_YEL1:  return V_LEFT;
            V_LEFT:  return V_YEL2;
            default: return H_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one phase tick every TICK_DIV clocks
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic o_tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign o_tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || o_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - parametrised two-axis intersection controller with walkers and night mode
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 2,
    parameter int T_LEFT   = 10,
    parameter int T_FLASH  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_night,
    input  logic       i_h_walk_req,
    input  logic       i_v_walk_req,
    output logic [3:0] o_h_car_traffic,
    output logic [3:0] o_v_car_traffic,
    output logic [1:0] o_h_walker_traffic,
    output logic [1:0] o_v_walker_traffic,
    output logic [3:0] o_state,
    output logic       o_cycle_done
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             tick, clr;
    logic             blink, blink_n;
    logic             h_req, h_req_n, v_req, v_req_n;
    logic             h_grant, h_grant_n, v_grant, v_grant_n;
    logic             done_n, in_flash;
    logic [3:0]       h_car_n, v_car_n;
    logic [1:0]       h_walk_n, v_walk_n, walk_lamp;

    assign clr     = (state == IDLE) || !i_start;
    assign o_state = state;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .o_tick (tick)
    );

    function automatic logic [CNT_W-1:0] phase_load(input state_t s);
        case (s)
            H_GREEN, V_GREEN:               return CNT_W'(T_GREEN - 1);
            H_YEL1, H_YEL2, V_YEL1, V_YEL2: return CNT_W'(T_YELLOW - 1);
            H_LEFT, V_LEFT:                 return CNT_W'(T_LEFT - 1);
            default:                        return '0;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        blink_n   = blink;
        h_req_n   = h_req | i_h_walk_req;
        v_req_n   = v_req | i_v_walk_req;
        h_grant_n = h_grant;
        v_grant_n = v_grant;
        done_n    = 1'b0;
        if (!i_start) begin
            state_n   = IDLE;
            cnt_n     = '0;
            blink_n   = 1'b0;
            h_req_n   = 1'b0;
            v_req_n   = 1'b0;
            h_grant_n = 1'b0;
            v_grant_n = 1'b0;
        end else begin
            if (state == IDLE) begin
                state_n = H_GREEN;
            end else if (tick) begin
                if (state == NIGHT) begin
                    if (!i_night)
                        state_n = H_GREEN;
                end else if (cnt == '0) begin
                    state_n = ring_next(state);
                    if (state == V_YEL2) begin
                        done_n = 1'b1;
                        if (i_night)
                            state_n = NIGHT;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            // A request on the entry clock is already folded into *_req_n, so it is granted now.
            if (state_n != state) begin
                cnt_n     = phase_load(state_n);
                blink_n   = 1'b0;
                h_grant_n = 1'b0;
                v_grant_n = 1'b0;
                if (state_n == H_GREEN) begin
                    v_grant_n = v_req_n;
                    v_req_n   = 1'b0;
                end
                if (state_n == V_GREEN) begin
                    h_grant_n = h_req_n;
                    h_req_n   = 1'b0;
                end
            end else if (tick && state != IDLE) begin
                // Re-phase the blink as the flash window opens so it always starts on GREEN.
                if ((state == H_GREEN || state == V_GREEN) && cnt == CNT_W'(T_FLASH))
                    blink_n = 1'b0;
                else
                    blink_n = ~blink;
            end
        end
    end

    always_comb begin
        in_flash  = (cnt_n < CNT_W'(T_FLASH));
        walk_lamp = (in_flash && blink_n) ? W_NONE : W_GREEN;
        h_car_n   = C_NONE;
        v_car_n   = C_NONE;
        h_walk_n  = W_NONE;
        v_walk_n  = W_NONE;
        case (state_n)
            H_GREEN, H_YEL1, H_LEFT, H_YEL2: begin
                v_car_n  = C_RED;
                h_walk_n = W_RED;
                v_walk_n = W_RED;
                case (state_n)
                    H_GREEN: begin
                        h_car_n = C_GREEN;
                        if (v_grant_n)
                            v_walk_n = walk_lamp;
                    end
                    H_LEFT:  h_car_n = C_LEFT;
                    default: h_car_n = C_YELLOW;
                endcase
            end
            V_GREEN, V_YEL1, V_LEFT, V_YEL2: begin
                h_car_n  = C_RED;
                h_walk_n = W_RED;
                v_walk_n = W_RED;
                case (state_n)
                    V_GREEN: begin
                        v_car_n = C_GREEN;
                        if (h_grant_n)
                            h_walk_n = walk_lamp;
                    end
                    V_LEFT:  v_car_n = C_LEFT;
                    default: v_car_n = C_YELLOW;
                endcase
            end
            NIGHT: begin
                h_car_n = blink_n ? C_NONE : C_YELLOW;
                v_car_n = blink_n ? C_NONE : C_YELLOW;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            blink              <= 1'b0;
            h_req              <= 1'b0;
            v_req              <= 1'b0;
            h_grant            <= 1'b0;
            v_grant            <= 1'b0;
            o_cycle_done       <= 1'b0;
            o_h_car_traffic    <= C_NONE;
            o_v_car_traffic    <= C_NONE;
            o_h_walker_traffic <= W_NONE;
            o_v_walker_traffic <= W_NONE;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            blink              <= blink_n;
            h_req              <= h_req_n;
            v_req              <= v_req_n;
            h_grant            <= h_grant_n;
            v_grant            <= v_grant_n;
            o_cycle_done       <= done_n;
            o_h_car_traffic    <= h_car_n;
            o_v_car_traffic    <= v_car_n;
            o_h_walker_traffic <= h_walk_n;
            o_v_walker_traffic <= v_walk_n;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb/tb_traffic_ctrl_param.sv - directed self-checking bench for traffic_ctrl_param
module tb_traffic_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_night = 1'b0;
    logic       i_h_walk_req = 1'b0;
    logic       i_v_walk_req = 1'b0;
    logic [3:0] o_h_car_traffic, o_v_car_traffic, o_state;
    logic [1:0] o_h_walker_traffic, o_v_walker_traffic;
    logic       o_cycle_done;
    logic [16:0] got, exp_v;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    traffic_ctrl_param #(
        .TICK_DIV (2),
        .CNT_W    (8),
        .T_GREEN  (4),
        .T_YELLOW (1),
        .T_LEFT   (2),
        .T_FLASH  (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_start            (i_start),
        .i_night            (i_night),
        .i_h_walk_req       (i_h_walk_req),
        .i_v_walk_req       (i_v_walk_req),
        .o_h_car_traffic    (o_h_car_traffic),
        .o_v_car_traffic    (o_v_car_traffic),
        .o_h_walker_traffic (o_h_walker_traffic),
        .o_v_walker_traffic (o_v_walker_traffic),
        .o_state            (o_state),
        .o_cycle_done       (o_cycle_done)
    );

    // {state, h_car, v_car, h_walk, v_walk, cycle_done}
    assign got = {o_state, o_h_car_traffic, o_v_car_traffic,
                  o_h_walker_traffic, o_v_walker_traffic, o_cycle_done};

    // Ring position c clocks after H_GREEN entry (8/2/4/2 clocks per H phase, same for V).
    function automatic logic [3:0] ring_state(input int c);
        int m;
        m = c % 32;
        if (m < 8)  return 4'd1;
        if (m < 10) return 4'd2;
        if (m < 14) return 4'd3;
        if (m < 16) return 4'd4;
        if (m < 24) return 4'd5;
        if (m < 26) return 4'd6;
        if (m < 30) return 4'd7;
        return 4'd8;
    endfunction

    function automatic logic [7:0] cars(input logic [3:0] s, input logic off);
        case (s)
            4'd1:       return {4'b0001, 4'b1000};
            4'd2, 4'd4: return {4'b0100, 4'b1000};
            4'd3:       return {4'b0010, 4'b1000};
            4'd5:       return {4'b1000, 4'b0001};
            4'd6, 4'd8: return {4'b1000, 4'b0100};
            4'd7:       return {4'b1000, 4'b0010};
            4'd9:       return off ? 8'h00 : {4'b0100, 4'b0100};
            default:    return 8'h00;
        endcase
    endfunction

    task automatic restart();
        i_start = 1'b0;
        i_night = 1'b0;
        i_h_walk_req = 1'b0;
        i_v_walk_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_start = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (got !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_state got=%h exp=%h", got, 17'h0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (got !== 17'h0) begin
            tests_failed++;
            $display("FAIL idle_no_start got=%h exp=%h", got, 17'h0);
        end
    endtask

    task automatic test_ring();
        logic [3:0] s;
        restart();
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            s = ring_state(c);
            exp_v = {s, cars(s, 1'b0), 4'b1010, (c == 32)};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL ring c=%0d got=%h exp=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_walk_v();
        logic [3:0] s;
        logic [1:0] vw;
        restart();
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            s = ring_state(c);
            if (c >= 32 && c < 38)      vw = 2'b01;
            else if (c >= 38 && c < 40) vw = 2'b00;
            else                        vw = 2'b10;
            exp_v = {s, cars(s, 1'b0), 2'b10, vw, (c == 32 || c == 64)};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL walk_v c=%0d got=%h exp=%h", c, got, exp_v);
            end
            i_v_walk_req = (c == 10);
        end
    endtask

    task automatic test_walk_h_same_clock();
        logic [3:0] s;
        logic [1:0] hw;
        restart();
        for (int c = 0; c < 57; c++) begin
            @(negedge clk);
            s = ring_state(c);
            if (c >= 16 && c < 22)      hw = 2'b01;
            else if (c >= 22 && c < 24) hw = 2'b00;
            else                        hw = 2'b10;
            exp_v = {s, cars(s, 1'b0), hw, 2'b10, (c == 32)};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL walk_h c=%0d got=%h exp=%h", c, got, exp_v);
            end
            i_h_walk_req = (c == 15);
        end
    endtask

    task automatic test_night();
        logic [3:0] s;
        logic [3:0] w;
        logic       off;
        restart();
        for (int c = 0; c < 49; c++) begin
            @(negedge clk);
            off = 1'b0;
            w = 4'b1010;
            if (c < 32) begin
                s = ring_state(c);
            end else if (c < 40) begin
                s = 4'd9;
                off = (((c - 32) / 2) % 2) == 1;
                w = 4'b0000;
            end else begin
                s = ring_state(c - 40);
            end
            exp_v = {s, cars(s, off), w, (c == 32)};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL night c=%0d got=%h exp=%h", c, got, exp_v);
            end
            if (c == 20) i_night = 1'b1;
            if (c == 38) i_night = 1'b0;
        end
    endtask

    task automatic test_start_low();
        logic [3:0] s;
        restart();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 28) begin
                s = ring_state(c);
                exp_v = {s, cars(s, 1'b0), 4'b1010, 1'b0};
            end else if (c < 30) begin
                exp_v = 17'h0;
            end else begin
                s = ring_state(c - 30);
                exp_v = {s, cars(s, 1'b0), 4'b1010, 1'b0};
            end
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL start_low c=%0d got=%h exp=%h", c, got, exp_v);
            end
            if (c == 27) i_start = 1'b0;
            if (c == 29) i_start = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] s;
        restart();
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (got !== 17'h0) begin
            tests_failed++;
            $display("FAIL async_reset_immediate got=%h exp=%h", got, 17'h0);
        end
        @(negedge clk);
        tests_run++;
        if (got !== 17'h0) begin
            tests_failed++;
            $display("FAIL async_reset_held got=%h exp=%h", got, 17'h0);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s = ring_state(c);
            exp_v = {s, cars(s, 1'b0), 4'b1010, 1'b0};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL async_restart c=%0d got=%h exp=%h", c, got, exp_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ring();
        test_walk_v();
        test_walk_h_same_clock();
        test_night();
        test_start_low();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
